// File: rtl/slavefifo_pkg.sv
// Shared definitions for the slave-FIFO packet generator: write-mode
// encodings, engine state encoding and the PRBS-31 constants.
package slavefifo_pkg;

   localparam logic [1:0] MODE_STREAM = 2'd0;
   localparam logic [1:0] MODE_SHORT  = 2'd1;
   localparam logic [1:0] MODE_ZLP    = 2'd2;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WAIT_FLAGB = 3'd1,
      WRITE      = 3'd2,
      WR_DELAY   = 3'd3,
      PKTEND     = 3'd4,
      GAP        = 3'd5
   } state_t;

   // PRBS-31, polynomial x^31 + x^28 + 1 (Fibonacci form).
   localparam logic [30:0] PRBS_SEED  = 31'h7FFF_FFFF;
   localparam int          PRBS_TAP_A = 30;
   localparam int          PRBS_TAP_B = 27;

   function automatic logic [30:0] prbs_next(input logic [30:0] s);
      return {s[29:0], s[PRBS_TAP_A] ^ s[PRBS_TAP_B]};
   endfunction

endpackage

// File: rtl/slavefifo_data_src.sv
// Write-data source: incrementing counter, or a PRBS-31 LFSR when
// SLAVEFIFO_PKT_GEN_PRBS_EN is defined. Advances once per write cycle;
// clear returns it to its start value and takes priority over advance.
module slavefifo_data_src
   import slavefifo_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk_100,
   input  logic              reset_,
   input  logic              advance,
   input  logic              clear,
   output logic [DATA_W-1:0] data
);

`ifdef SLAVEFIFO_PKT_GEN_PRBS_EN
   logic [30:0] lfsr;
   logic [31:0] lfsr_ext;

   // LFSR state: seeded on reset and clear, stepped on each write.
   always_ff @(posedge clk_100 or negedge reset_) begin
      if (!reset_)
         lfsr <= PRBS_SEED;
      else if (clear)
         lfsr <= PRBS_SEED;
      else if (advance)
         lfsr <= prbs_next(lfsr);
   end

   assign lfsr_ext = {1'b0, lfsr};
   assign data     = lfsr_ext[DATA_W-1:0];
`else
   logic [DATA_W-1:0] cnt;

   // Data counter: wraps naturally at 2^DATA_W.
   always_ff @(posedge clk_100 or negedge reset_) begin
      if (!reset_)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (advance)
         cnt <= cnt + DATA_W'(1);
   end

   assign data = cnt;
`endif

endmodule

// File: rtl/slavefifo_pkt_gen.sv
// Slave-FIFO write-path packet generator covering streaming, short
// packets and zero-length packets. Strobes decode from the registered
// state so they never glitch. Optional macro SLAVEFIFO_PKT_GEN_PRBS_EN
// swaps the counter data for PRBS-31 data.
module slavefifo_pkt_gen
   import slavefifo_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 12,
   parameter int GAP_W  = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk_100,
   input  logic              reset_,
   input  logic              enable,
   input  logic [1:0]        mode,
   input  logic [LEN_W-1:0]  pkt_len,
   input  logic [GAP_W-1:0]  gap_cycles,
   input  logic              flaga_d,
   input  logic              flagb_d,
   output logic              slwr_,
   output logic              pktend_,
   output logic [DATA_W-1:0] data_out,
   output logic [CNT_W-1:0]  pkt_count,
   output logic              busy
);

   state_t            state, state_next;
   logic [1:0]        m_mode, mode_eff;
   logic [LEN_W-1:0]  m_len, word_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic              start, pkt_done;

   // Engine state register.
   always_ff @(posedge clk_100 or negedge reset_) begin
      if (!reset_)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next state, packet start/complete pulses, and the mode to latch.
   always_comb begin
      state_next = state;
      start      = 1'b0;
      pkt_done   = 1'b0;
      mode_eff   = MODE_STREAM;
      if (mode == MODE_SHORT)
         mode_eff = (pkt_len == '0) ? MODE_ZLP : MODE_SHORT;
      else if (mode == MODE_ZLP)
         mode_eff = MODE_ZLP;

      if (!enable) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (flaga_d) begin
                  state_next = WAIT_FLAGB;
                  start      = 1'b1;
               end
            end
            WAIT_FLAGB: begin
               if (flagb_d)
                  state_next = (m_mode == MODE_ZLP) ? PKTEND : WRITE;
            end
            WRITE: begin
               if (!flagb_d)
                  state_next = WR_DELAY;
               else if (m_mode == MODE_SHORT && word_cnt == m_len - LEN_W'(1))
                  state_next = PKTEND;
            end
            WR_DELAY: begin
               if (m_mode == MODE_STREAM) begin
                  state_next = GAP;
                  pkt_done   = 1'b1;
               end else if (m_mode == MODE_SHORT && word_cnt < m_len) begin
                  state_next = WAIT_FLAGB;
               end else begin
                  state_next = PKTEND;
               end
            end
            PKTEND: begin
               state_next = GAP;
               pkt_done   = 1'b1;
            end
            GAP: begin
               if (gap_cnt == gap_cycles)
                  state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Per-packet context, word/gap counters and the completed-packet count.
   always_ff @(posedge clk_100 or negedge reset_) begin
      if (!reset_) begin
         m_mode    <= MODE_STREAM;
         m_len     <= '0;
         word_cnt  <= '0;
         gap_cnt   <= '0;
         pkt_count <= '0;
      end else begin
         if (start) begin
            m_mode   <= mode_eff;
            m_len    <= pkt_len;
            word_cnt <= '0;
            gap_cnt  <= '0;
         end else begin
            if (state == WRITE)
               word_cnt <= word_cnt + LEN_W'(1);
            if (state == GAP)
               gap_cnt <= gap_cnt + GAP_W'(1);
         end
         if (pkt_done)
            pkt_count <= pkt_count + CNT_W'(1);
      end
   end

   slavefifo_data_src #(
      .DATA_W (DATA_W)
   ) u_data_src (
      .clk_100 (clk_100),
      .reset_  (reset_),
      .advance (state == WRITE),
      .clear   (!enable),
      .data    (data_out)
   );

   assign slwr_   = (state != WRITE);
   assign pktend_ = (state != PKTEND);
   assign busy    = (state != IDLE);

endmodule

// File: tb/tb_slavefifo_pkt_gen.sv
// Self-checking bench for slavefifo_pkt_gen. Expected write data is pushed
// to a queue when a scenario starts; words observed on the bus are
// collected and popped against it. Define SLAVEFIFO_PKT_GEN_PRBS_EN for
// both bench and RTL to check the PRBS-31 data path.
module tb_slavefifo_pkt_gen;

   localparam int DATA_W = 32;
   localparam int LEN_W  = 12;
   localparam int GAP_W  = 4;
   localparam int CNT_W  = 16;

   logic              clk_100 = 1'b0;
   logic              reset_  = 1'b0;
   logic              enable  = 1'b0;
   logic [1:0]        mode    = 2'd0;
   logic [LEN_W-1:0]  pkt_len = '0;
   logic [GAP_W-1:0]  gap_cycles = '0;
   logic              flaga_d = 1'b0;
   logic              flagb_d = 1'b0;
   logic              slwr_;
   logic              pktend_;
   logic [DATA_W-1:0] data_out;
   logic [CNT_W-1:0]  pkt_count;
   logic              busy;

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] obs_q[$];
   int wr_cnt, pk_cnt, wr_at_pk, gap_run, last_gap;
   bit in_gap;

   slavefifo_pkt_gen #(
      .DATA_W (DATA_W),
      .LEN_W  (LEN_W),
      .GAP_W  (GAP_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk_100    (clk_100),
      .reset_     (reset_),
      .enable     (enable),
      .mode       (mode),
      .pkt_len    (pkt_len),
      .gap_cycles (gap_cycles),
      .flaga_d    (flaga_d),
      .flagb_d    (flagb_d),
      .slwr_      (slwr_),
      .pktend_    (pktend_),
      .data_out   (data_out),
      .pkt_count  (pkt_count),
      .busy       (busy)
   );

   always #5 clk_100 = ~clk_100;

   // Reference data model.
`ifdef SLAVEFIFO_PKT_GEN_PRBS_EN
   logic [30:0] mdl;
   function automatic logic [DATA_W-1:0] rst_word();
      return 32'h7FFF_FFFF;
   endfunction
   task automatic model_clear();
      mdl = 31'h7FFF_FFFF;
   endtask
   task automatic model_push(input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({1'b0, mdl});
         mdl = {mdl[29:0], mdl[30] ^ mdl[27]};
      end
   endtask
   function automatic logic [DATA_W-1:0] model_cur();
      return {1'b0, mdl};
   endfunction
`else
   logic [DATA_W-1:0] mdl;
   function automatic logic [DATA_W-1:0] rst_word();
      return '0;
   endfunction
   task automatic model_clear();
      mdl = '0;
   endtask
   task automatic model_push(input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(mdl);
         mdl = mdl + 1;
      end
   endtask
   function automatic logic [DATA_W-1:0] model_cur();
      return mdl;
   endfunction
`endif

   // Advance to the next falling edge and record bus activity.
   task automatic tick();
      @(negedge clk_100);
      if (!slwr_) begin
         obs_q.push_back(data_out);
         wr_cnt++;
      end
      if (!pktend_) begin
         pk_cnt++;
         wr_at_pk = wr_cnt;
         in_gap   = 1'b1;
         gap_run  = 0;
      end else if (in_gap) begin
         if (busy) gap_run++;
         else begin
            in_gap   = 1'b0;
            last_gap = gap_run;
         end
      end
   endtask

   task automatic do_reset();
      reset_  = 1'b0;
      enable  = 1'b0;
      flaga_d = 1'b0;
      flagb_d = 1'b0;
      exp_q.delete();
      obs_q.delete();
      wr_cnt = 0; pk_cnt = 0; wr_at_pk = -1; gap_run = 0; last_gap = -1;
      in_gap = 1'b0;
      model_clear();
      repeat (2) @(negedge clk_100);
      reset_ = 1'b1;
   endtask

   task automatic test_reset();
      reset_ = 1'b0;
      #1;
      checks++; if (slwr_ !== 1'b1) begin errors++; $display("FAIL reset_slwr: got %b expected 1", slwr_); end
      checks++; if (pktend_ !== 1'b1) begin errors++; $display("FAIL reset_pktend: got %b expected 1", pktend_); end
      checks++; if (data_out !== rst_word()) begin errors++; $display("FAIL reset_data: got %h expected %h", data_out, rst_word()); end
      checks++; if (pkt_count !== '0) begin errors++; $display("FAIL reset_pkt_count: got %0d expected 0", pkt_count); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      $display("test_reset: outputs checked under reset");
   endtask

   task automatic test_short();
      bit done = 0;
      bit changed = 0;
      logic [DATA_W-1:0] got, want;
      do_reset();
      mode = 2'd1; pkt_len = 5; gap_cycles = 2;
      flaga_d = 1'b1; flagb_d = 1'b1; enable = 1'b1;
      model_push(5);
      for (int c = 0; c < 100; c++) begin
         tick();
         if (wr_cnt >= 1 && !changed) begin
            mode = 2'd0; pkt_len = 50; changed = 1;   // must be ignored while busy
         end
         if (pk_cnt >= 1 && !busy) begin done = 1; break; end
      end
      enable = 1'b0;
      checks++; if (!done) begin errors++; $display("FAIL short_timeout: packet not finished in 100 cycles"); end
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL short_words: got %0d writes expected %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         got = obs_q.pop_front(); want = exp_q.pop_front();
         checks++; if (got !== want) begin errors++; $display("FAIL short_data: got %h expected %h", got, want); end
      end
      checks++; if (pk_cnt != 1) begin errors++; $display("FAIL short_pktend: got %0d pulses expected 1", pk_cnt); end
      checks++; if (wr_at_pk != 5) begin errors++; $display("FAIL short_pktend_pos: after %0d writes expected 5", wr_at_pk); end
      checks++; if (last_gap != 3) begin errors++; $display("FAIL short_gap: got %0d gap cycles expected 3", last_gap); end
      checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL short_pkt_count: got %0d expected 1", pkt_count); end
      $display("test_short: writes=%0d pktends=%0d gap=%0d pkt_count=%0d", wr_cnt, pk_cnt, last_gap, pkt_count);
   endtask

   task automatic test_zlp();
      bit done = 0;
      do_reset();
      mode = 2'd2; pkt_len = 7; gap_cycles = 0;
      flaga_d = 1'b1; flagb_d = 1'b1; enable = 1'b1;
      for (int c = 0; c < 200; c++) begin
         tick();
         if (pk_cnt >= 4 && !busy) begin done = 1; break; end
      end
      enable = 1'b0;
      checks++; if (!done) begin errors++; $display("FAIL zlp_timeout: 4 packets not seen in 200 cycles"); end
      checks++; if (wr_cnt != 0) begin errors++; $display("FAIL zlp_writes: got %0d expected 0", wr_cnt); end
      checks++; if (pk_cnt != 4) begin errors++; $display("FAIL zlp_pktend: got %0d expected 4", pk_cnt); end
      checks++; if (pkt_count !== 16'd4) begin errors++; $display("FAIL zlp_pkt_count: got %0d expected 4", pkt_count); end
      checks++; if (data_out !== rst_word()) begin errors++; $display("FAIL zlp_data: got %h expected %h", data_out, rst_word()); end
      $display("test_zlp: pktends=%0d pkt_count=%0d", pk_cnt, pkt_count);
   endtask

   task automatic test_flagb_pause();
      bit done = 0;
      bit paused = 0;
      int hold = 0;
      logic [DATA_W-1:0] got, want;
      do_reset();
      mode = 2'd1; pkt_len = 8; gap_cycles = 1;
      flaga_d = 1'b1; flagb_d = 1'b1; enable = 1'b1;
      model_push(8);
      for (int c = 0; c < 200; c++) begin
         tick();
         if (paused && !flagb_d) begin
            hold++;
            if (hold == 4) flagb_d = 1'b1;
         end
         if (wr_cnt == 3 && !paused) begin flagb_d = 1'b0; paused = 1; end
         if (pk_cnt >= 1 && !busy) begin done = 1; break; end
      end
      enable = 1'b0;
      checks++; if (!done) begin errors++; $display("FAIL pause_timeout: packet not finished in 200 cycles"); end
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL pause_words: got %0d writes expected %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         got = obs_q.pop_front(); want = exp_q.pop_front();
         checks++; if (got !== want) begin errors++; $display("FAIL pause_data: got %h expected %h", got, want); end
      end
      checks++; if (pk_cnt != 1) begin errors++; $display("FAIL pause_pktend: got %0d expected 1", pk_cnt); end
      checks++; if (wr_at_pk != 8) begin errors++; $display("FAIL pause_pktend_pos: after %0d writes expected 8", wr_at_pk); end
      checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL pause_pkt_count: got %0d expected 1", pkt_count); end
      $display("test_flagb_pause: writes=%0d pktends=%0d pkt_count=%0d", wr_cnt, pk_cnt, pkt_count);
   endtask

   task automatic test_stream();
      bit done = 0;
      logic [DATA_W-1:0] got, want;
      do_reset();
      mode = 2'd0; pkt_len = 3; gap_cycles = 0;
      flaga_d = 1'b1; flagb_d = 1'b1; enable = 1'b1;
      model_push(1024);
      for (int c = 0; c < 1200; c++) begin
         tick();
         if (wr_cnt == 1024) begin flagb_d = 1'b0; done = 1; break; end
      end
      repeat (6) tick();
      checks++; if (!done) begin errors++; $display("FAIL stream_timeout: 1024 writes not seen in 1200 cycles"); end
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL stream_words: got %0d writes expected %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         got = obs_q.pop_front(); want = exp_q.pop_front();
         checks++; if (got !== want) begin errors++; $display("FAIL stream_data: got %h expected %h", got, want); end
      end
      checks++; if (pk_cnt != 0) begin errors++; $display("FAIL stream_pktend: got %0d expected 0", pk_cnt); end
      checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL stream_pkt_count: got %0d expected 1", pkt_count); end
      checks++; if (data_out !== model_cur()) begin errors++; $display("FAIL stream_data_out: got %h expected %h", data_out, model_cur()); end
      enable = 1'b0;
      $display("test_stream: writes=%0d pktends=%0d pkt_count=%0d data_out=%h", wr_cnt, pk_cnt, pkt_count, data_out);
   endtask

   task automatic test_abort();
      bit done = 0;
      logic [DATA_W-1:0] got, want;
      do_reset();
      mode = 2'd1; pkt_len = 100; gap_cycles = 0;
      flaga_d = 1'b1; flagb_d = 1'b1; enable = 1'b1;
      model_push(10);
      for (int c = 0; c < 200; c++) begin
         tick();
         if (wr_cnt == 10) begin enable = 1'b0; done = 1; break; end
      end
      tick();
      checks++; if (!done) begin errors++; $display("FAIL abort_timeout: 10 writes not seen in 200 cycles"); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
      checks++; if (data_out !== rst_word()) begin errors++; $display("FAIL abort_data_out: got %h expected %h", data_out, rst_word()); end
      checks++; if (pkt_count !== '0) begin errors++; $display("FAIL abort_pkt_count: got %0d expected 0", pkt_count); end
      checks++; if (pk_cnt != 0) begin errors++; $display("FAIL abort_pktend: got %0d expected 0", pk_cnt); end
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL abort_words: got %0d writes expected %0d", obs_q.size(), exp_q.size()); end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         got = obs_q.pop_front(); want = exp_q.pop_front();
         checks++; if (got !== want) begin errors++; $display("FAIL abort_data: got %h expected %h", got, want); end
      end
      $display("test_abort: writes=%0d busy=%b data_out=%h pkt_count=%0d", wr_cnt, busy, data_out, pkt_count);
   endtask

   task automatic test_async_reset();
      bit done = 0;
      do_reset();
      mode = 2'd0; gap_cycles = 0;
      flaga_d = 1'b1; flagb_d = 1'b1; enable = 1'b1;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (wr_cnt == 5) begin done = 1; break; end
      end
      #2 reset_ = 1'b0;
      #1;
      checks++; if (!done) begin errors++; $display("FAIL arst_timeout: writes not seen in 100 cycles"); end
      checks++; if (slwr_ !== 1'b1) begin errors++; $display("FAIL arst_slwr: got %b expected 1", slwr_); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", busy); end
      checks++; if (data_out !== rst_word()) begin errors++; $display("FAIL arst_data: got %h expected %h", data_out, rst_word()); end
      $display("test_async_reset: stream reset mid-write slwr_=%b data_out=%h", slwr_, data_out);

      do_reset();
      done = 0;
      mode = 2'd2; gap_cycles = 0;
      flaga_d = 1'b1; flagb_d = 1'b1; enable = 1'b1;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (pk_cnt >= 1) begin done = 1; break; end
      end
      #2 reset_ = 1'b0;
      #1;
      checks++; if (!done) begin errors++; $display("FAIL arst_zlp_timeout: pktend not seen in 100 cycles"); end
      checks++; if (pktend_ !== 1'b1) begin errors++; $display("FAIL arst_pktend: got %b expected 1", pktend_); end
      checks++; if (pkt_count !== '0) begin errors++; $display("FAIL arst_pkt_count: got %0d expected 0", pkt_count); end
      $display("test_async_reset: reset during pktend pktend_=%b pkt_count=%0d", pktend_, pkt_count);
      enable = 1'b0;
   endtask

   initial begin
      test_reset();
      test_short();
      test_zlp();
      test_flagb_pause();
      test_stream();
      test_abort();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
